instr_prefetch: RTL

Instruction prefetch queue sitting directly upstream of the KySMet multi-cycle processor's decode/execute state machine. Streams 16-bit words from main memory at sequential addresses into a small FIFO and presents them, with their word address, to the processor through a valid/ready handshake. A redirect from the processor (jump, jumpf taken, call, ret, trap) flushes the queue and restarts fetch at a new address; `li` immediates are simply the next popped word.

---
 rtl/kysmet_pkg.sv | 34 +++
 rtl/prefetch_fifo.sv | 84 ++++++++
 rtl/instr_prefetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/kysmet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kysmet_pkg
//  Description : Shared definitions for the KySMet processor front end:
//                datapath widths, prefetch FSM state encoding and the
//                opcode values the processor decodes as fetch redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
package kysmet_pkg;

    localparam int c_WORD_W = 16;
    localparam int c_ADDR_W = 16;

    // Prefetch FSM state encoding
    localparam logic [1:0] c_PF_IDLE   = 2'd0;
    localparam logic [1:0] c_PF_RUN    = 2'd1;
    localparam logic [1:0] c_PF_HALTED = 2'd2;

    // Major opcodes (instruction bits [15:12])
    localparam logic [3:0] c_OP_LI    = 4'h1;
    localparam logic [3:0] c_OP_JUMP  = 4'h8;
    localparam logic [3:0] c_OP_JUMPF = 4'h9;
    localparam logic [3:0] c_OP_CALL  = 4'hA;
    localparam logic [3:0] c_OP_RET   = 4'hB;
    localparam logic [3:0] c_OP_TRAP  = 4'hF;

    // True for opcodes that can change the fetch stream (jumpf only when taken)
    function automatic logic is_flow_op(input logic [3:0] op);
        return (op == c_OP_JUMP) || (op == c_OP_JUMPF) || (op == c_OP_CALL) ||
               (op == c_OP_RET)  || (op == c_OP_TRAP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_fifo
//  Description : DEPTH-entry synchronous FIFO of {word, pc} pairs with a
//                flush that overrides push and pop, simultaneous push/pop
//                (legal when full) and an occupancy count output.
//  Ports       : clk, reset (async, active-high)
//                flush            - empty the queue this cycle
//                push/push_word/push_pc - write an entry
//                pop              - remove the head entry
//                head_word/head_pc - head entry registers
//                count            - number of valid entries (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WW    = 16,
    parameter int AW    = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [WW-1:0] push_word,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    output logic [WW-1:0] head_word,
    output logic [AW-1:0] head_pc,
    output logic [CW-1:0] count
);

    localparam int            c_PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    logic [WW-1:0]   r_word [DEPTH];
    logic [AW-1:0]   r_pc   [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    // Pop only a real entry; push at full only when the head leaves together
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != c_FULL) || w_do_pop);

    assign head_word = r_word[r_rd_ptr];
    assign head_pc   = r_pc[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_word[i] <= '0;
                r_pc[i]   <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_word[r_wr_ptr] <= push_word;
                r_pc[r_wr_ptr]   <= push_pc;
                r_wr_ptr         <= r_wr_ptr + c_PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch
//  Description : Instruction prefetch queue in front of the KySMet
//                decode/execute FSM. Fetches sequential 16-bit words from
//                memory (one-cycle read latency) into a small FIFO and hands
//                them out with their address over a valid/ready handshake.
//                A redirect flushes the queue and restarts fetch.
//  Ports       : clk, reset (async, active-high), halt
//                mem_req/mem_addr/mem_rdata  - memory read port
//                redirect/redirect_pc        - flush and restart fetch
//                ir_valid/ir_ready/ir_word/ir_pc - processor handshake
//                stat_fetch/stat_flush       - only with INSTR_PREFETCH_STATS_EN
//  Config      : INSTR_PREFETCH_STATS_EN adds wrapping 16-bit counters of
//                pushed words and of redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch
    import kysmet_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = c_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,
    output logic                mem_req,
    output logic [AW-1:0]       mem_addr,
    input  logic [c_WORD_W-1:0] mem_rdata,
    input  logic                redirect,
    input  logic [AW-1:0]       redirect_pc,
    output logic                ir_valid,
    input  logic                ir_ready,
    output logic [c_WORD_W-1:0] ir_word,
    output logic [AW-1:0]       ir_pc
`ifdef INSTR_PREFETCH_STATS_EN
    ,
    output logic [15:0]         stat_fetch,
    output logic [15:0]         stat_flush
`endif
);

    localparam int          c_CW    = $clog2(DEPTH + 1);
    localparam logic [c_CW:0] c_LIMIT = (c_CW + 1)'(DEPTH);

    logic [1:0]      r_state;
    logic [AW-1:0]   r_fetch_pc;
    logic            r_inflight;
    logic [AW-1:0]   r_inflight_pc;
    logic            r_stale;

    logic [c_CW-1:0] w_count;
    logic [c_CW:0]   w_occupancy;
    logic            w_flush;
    logic            w_push;
    logic            w_pop;

    // Queued entries plus the one word still on its way back from memory
    assign w_occupancy = {1'b0, w_count} + {{c_CW{1'b0}}, r_inflight};

    // Redirects are ignored until the FSM has left IDLE
    assign w_flush = redirect && (r_state != c_PF_IDLE);

    assign mem_req  = (r_state == c_PF_RUN) && !redirect && (w_occupancy < c_LIMIT);
    assign mem_addr = r_fetch_pc;

    // r_stale is set for the cycle after a flush; no request issues in a
    // redirect cycle, so it only guards a return that should never exist.
    assign w_push   = r_inflight && !r_stale && !redirect;
    assign ir_valid = (r_state != c_PF_HALTED) && (w_count != '0);
    assign w_pop    = ir_valid && ir_ready && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_PF_IDLE;
            r_fetch_pc    <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_stale       <= 1'b0;
        end else begin
            // Memory answers exactly one cycle after each request
            r_inflight <= mem_req;
            r_stale    <= w_flush;

            if (w_flush) begin
                r_fetch_pc <= redirect_pc;
            end else if (mem_req) begin
                r_fetch_pc    <= r_fetch_pc + AW'(1);
                r_inflight_pc <= r_fetch_pc;
            end

            case (r_state)
                c_PF_IDLE:   r_state <= c_PF_RUN;
                c_PF_RUN:    if (!w_flush && halt) r_state <= c_PF_HALTED;
                c_PF_HALTED: if (w_flush) r_state <= c_PF_RUN;
                default:     r_state <= c_PF_IDLE;
            endcase
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WW    (c_WORD_W),
        .AW    (AW),
        .CW    (c_CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (w_flush),
        .push      (w_push),
        .push_word (mem_rdata),
        .push_pc   (r_inflight_pc),
        .pop       (w_pop),
        .head_word (ir_word),
        .head_pc   (ir_pc),
        .count     (w_count)
    );

`ifdef INSTR_PREFETCH_STATS_EN
    logic [15:0] r_stat_fetch;
    logic [15:0] r_stat_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_fetch <= '0;
            r_stat_flush <= '0;
        end else begin
            if (w_push && !w_flush) r_stat_fetch <= r_stat_fetch + 16'd1;
            if (w_flush)            r_stat_flush <= r_stat_flush + 16'd1;
        end
    end

    assign stat_fetch = r_stat_fetch;
    assign stat_flush = r_stat_flush;
`endif

endmodule
`default_nettype wire
